// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction memory with a valid/ready fetch port,
// a program-load write port and a hardware clear engine.
// Misaligned and out-of-range PCs are reported as faults and answered
// with NOP_WORD instead of aliasing onto a valid word.
module instr_mem_fetch #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  output logic [31:0]       rsp_pc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              clr_start,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Counter is one bit wider than the index so the end compare never wraps.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_instr_q, rsp_instr_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;

  logic [31:0]       mem_array [DEPTH];

  logic              accept;
  logic              pc_misaligned;
  logic              pc_out_of_range;
  logic [ADDR_W-1:0] rd_index;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  // Ready only when idle, no load pending and the output slot is free or
  // being drained; held low throughout reset.
  assign req_ready = (state_q == IDLE) & ~ld_en & (~rsp_valid_q | rsp_ready) & ~reset;
  assign accept    = req_valid & req_ready;

  // Range check uses the whole word address so high PCs never alias.
  assign pc_misaligned   = |req_pc[1:0];
  assign pc_out_of_range = req_pc[31:2] >= 30'(DEPTH);
  assign rd_index        = req_pc[ADDR_W+1:2];

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_pc    = rsp_pc_q;
  assign busy      = (state_q == CLEAR);

  // Single write port: the clear engine owns it in CLEAR, the loader in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q[ADDR_W-1:0];
      mem_wdata = NOP_WORD;
    end else if (ld_en) begin
      mem_we = 1'b1;
    end
  end

  // Backing array: plain write port with no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[mem_waddr] <= mem_wdata;
    end
  end

  // Clear engine: sweep every index once, then fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output slot: load on accept, drop when consumed, otherwise hold steady.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_fault_d = rsp_fault_q;
    rsp_pc_d    = rsp_pc_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc;
      rsp_fault_d = {pc_out_of_range, pc_misaligned};
      if (pc_misaligned | pc_out_of_range) begin
        rsp_instr_d = NOP_WORD;
      end else begin
        rsp_instr_d = mem_array[rd_index];
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State and response registers; reset aborts a clear and drops any response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_fault_q <= '0;
      rsp_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_pc_q    <= rsp_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a transaction-level model tracks the
// expected output slot, memory image and clear window; a negedge process
// compares every cycle, and the main sequence pins literal values.
module tb_instr_mem_fetch;

  localparam int          DEPTH  = 128;
  localparam int          ADDR_W = 7;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_pc    = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_instr;
  logic [1:0]        rsp_fault;
  logic [31:0]       rsp_pc;
  logic              ld_en     = 1'b0;
  logic [ADDR_W-1:0] ld_addr   = '0;
  logic [31:0]       ld_data   = '0;
  logic              clr_start = 1'b0;
  logic              busy;

  int checks = 0;
  int errors = 0;

  instr_mem_fetch #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .NOP_WORD(NOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_pc   (req_pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault),
    .rsp_pc   (rsp_pc),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .clr_start(clr_start),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Model state: expected output slot, memory image and clear progress.
  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [1:0]  m_fault = '0;
  logic [31:0] m_pc    = '0;
  bit          m_known = 1'b1;
  int          clr_left = 0;
  int          clr_idx  = 0;

  function automatic bit model_ready();
    return (clr_left == 0) && !ld_en && (!m_valid || rsp_ready) && !reset;
  endfunction

  function automatic logic [1:0] model_fault(input logic [31:0] pc);
    logic range_bad;
    logic align_bad;
    range_bad = (pc >> 2) >= 32'(DEPTH);
    align_bad = (pc % 4) != 0;
    return {range_bad, align_bad};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rr);
    req_valid = v;
    req_pc    = pc;
    rsp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input int addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(addr);
    ld_data = data;
    step();
    ld_en   = 1'b0;
  endtask

  // Transaction-level model advanced on every clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_instr  <= '0;
      m_fault  <= '0;
      m_pc     <= '0;
      m_known  <= 1'b1;
      if (clr_left != 0) begin
        for (int i = 0; i < DEPTH; i++) known[i] <= 1'b0;
      end
      clr_left <= 0;
      clr_idx  <= 0;
    end else begin
      if (req_valid && model_ready()) begin
        m_valid <= 1'b1;
        m_pc    <= req_pc;
        m_fault <= model_fault(req_pc);
        if (model_fault(req_pc) != 2'b00) begin
          m_instr <= NOP;
          m_known <= 1'b1;
        end else begin
          m_instr <= model_mem[req_pc[ADDR_W+1:2]];
          m_known <= known[req_pc[ADDR_W+1:2]];
        end
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
      if (clr_left > 0) begin
        model_mem[clr_idx] <= NOP;
        known[clr_idx]     <= 1'b1;
        clr_idx            <= clr_idx + 1;
        clr_left           <= clr_left - 1;
      end else begin
        if (ld_en) begin
          model_mem[ld_addr] <= ld_data;
          known[ld_addr]     <= 1'b1;
        end
        if (clr_start) begin
          clr_left <= DEPTH;
          clr_idx  <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    checkOutput("req_ready", 32'(req_ready), 32'(model_ready()));
    checkOutput("busy", 32'(busy), 32'(clr_left != 0));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    checkOutput("rsp_fault", 32'(rsp_fault), 32'(m_fault));
    checkOutput("rsp_pc", rsp_pc, m_pc);
    if (m_known) checkOutput("rsp_instr", rsp_instr, m_instr);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      known[i]     = 1'b0;
    end

    // Reset state
    repeat (3) step();
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_instr", rsp_instr, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    step();

    // Program load
    loadWord(0, 32'h0073_0293);
    loadWord(1, 32'h4073_0293);
    loadWord(2, 32'h0143_0293);
    loadWord(3, 32'h0283_2283);
    loadWord(127, 32'h0010_0073);

    // Basic back-to-back fetch
    applyStimulus(1'b1, 32'h0, 1'b1);
    step();
    checkOutput("fetch0_valid", 32'(rsp_valid), 32'd1);
    checkOutput("fetch0_instr", rsp_instr, 32'h0073_0293);
    checkOutput("fetch0_pc", rsp_pc, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b1);
    step();
    checkOutput("fetch1_instr", rsp_instr, 32'h4073_0293);
    applyStimulus(1'b1, 32'h8, 1'b1);
    step();
    checkOutput("fetch2_instr", rsp_instr, 32'h0143_0293);
    applyStimulus(1'b1, 32'hC, 1'b1);
    step();
    checkOutput("fetch3_instr", rsp_instr, 32'h0283_2283);
    checkOutput("fetch3_pc", rsp_pc, 32'hC);
    checkOutput("fetch3_fault", 32'(rsp_fault), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();

    // Backpressure
    applyStimulus(1'b1, 32'h4, 1'b1);
    step();
    applyStimulus(1'b1, 32'h8, 1'b0);
    #1;
    checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
    step();
    checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_hold_pc", rsp_pc, 32'h4);
    step();
    checkOutput("bp_hold_instr", rsp_instr, 32'h4073_0293);
    applyStimulus(1'b1, 32'h8, 1'b1);
    #1;
    checkOutput("bp_ready_high", 32'(req_ready), 32'd1);
    step();
    checkOutput("bp_next_pc", rsp_pc, 32'h8);
    checkOutput("bp_next_instr", rsp_instr, 32'h0143_0293);

    // Faults
    applyStimulus(1'b1, 32'h6, 1'b1);
    step();
    checkOutput("fault_mis", 32'(rsp_fault), 32'd1);
    checkOutput("fault_mis_instr", rsp_instr, 32'h0000_0013);
    applyStimulus(1'b1, 32'h200, 1'b1);
    step();
    checkOutput("fault_range", 32'(rsp_fault), 32'd2);
    applyStimulus(1'b1, 32'h8000_0000, 1'b1);
    step();
    checkOutput("fault_high", 32'(rsp_fault), 32'd2);
    checkOutput("fault_high_instr", rsp_instr, 32'h0000_0013);
    applyStimulus(1'b1, 32'h202, 1'b1);
    step();
    checkOutput("fault_both", 32'(rsp_fault), 32'd3);
    applyStimulus(1'b1, 32'h1FC, 1'b1);
    step();
    checkOutput("last_word_fault", 32'(rsp_fault), 32'd0);
    checkOutput("last_word_instr", rsp_instr, 32'h0010_0073);

    // Load/fetch collision
    applyStimulus(1'b1, 32'h8, 1'b1);
    ld_en   = 1'b1;
    ld_addr = 7'd2;
    ld_data = 32'h1234_5678;
    #1;
    checkOutput("collide_ready", 32'(req_ready), 32'd0);
    step();
    ld_en = 1'b0;
    checkOutput("collide_no_accept", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("raw_instr", rsp_instr, 32'h1234_5678);
    checkOutput("raw_pc", rsp_pc, 32'h8);

    // Clear with a response pending across its start
    applyStimulus(1'b1, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 1000) begin
      busy_cycles++;
      applyStimulus(1'b1, 32'h10, busy_cycles >= 5);
      ld_en     = (busy_cycles == 10);
      ld_addr   = 7'd3;
      ld_data   = 32'hAAAA_5555;
      clr_start = (busy_cycles == 20);
      step();
    end
    ld_en     = 1'b0;
    clr_start = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("clear_len", 32'(busy_cycles), 32'(DEPTH));
    applyStimulus(1'b1, 32'h0, 1'b1);
    step();
    checkOutput("clr_pc0", rsp_instr, 32'h0000_0013);
    applyStimulus(1'b1, 32'h1FC, 1'b1);
    step();
    checkOutput("clr_pc1fc", rsp_instr, 32'h0000_0013);
    applyStimulus(1'b1, 32'hC, 1'b1);
    step();
    checkOutput("clr_ld_ignored", rsp_instr, 32'h0000_0013);

    // Reset mid-clear with a response pending
    applyStimulus(1'b1, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (5) step();
    applyStimulus(1'b1, 32'h200, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    step();
    checkOutput("post_rst_valid", 32'(rsp_valid), 32'd1);
    checkOutput("post_rst_fault", 32'(rsp_fault), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b1);
    loadWord(5, 32'hCAFE_F00D);
    applyStimulus(1'b1, 32'h14, 1'b1);
    step();
    checkOutput("post_rst_instr", rsp_instr, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, synchronous-read instruction memory with a valid/ready fetch interface, a program-load write port and a hardware clear engine.
- Successor to the combinational instruction ROM.
- Sits between the PC/fetch stage and decode, and reports misaligned and out-of-range PCs as faults instead of aliasing them.
- Backing array maps to block RAM: registered read, no reset on contents.

Parameters:
- DEPTH, 128, number of 32-bit instruction words; power of two, ≥4.
- ADDR_W, 7, word-index width; must equal log2(DEPTH).
- NOP_WORD, 32'h00000013, word returned on fault and written by the clear engine (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_pc  in  32  byte address of the instruction.
- rsp_valid  out  1  response word held.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  32  fetched instruction, or NOP_WORD on fault.
- rsp_fault  out  2  00 ok, 01 misaligned (pc[1:0]≠0), 10 out of range (pc[31:2]≥DEPTH), 11 both.
- rsp_pc  out  32  echo of the accepted req_pc.
- ld_en  in  1  write ld_data at ld_addr this cycle.
- ld_addr  in  ADDR_W  word index for load.
- ld_data  in  32  word to load.
- clr_start  in  1  one-cycle pulse; starts the clear engine.
- busy  out  1  clear engine active.

Behaviour:
- Reset values: req_ready=0 while reset is asserted; rsp_valid=0, rsp_instr=0, rsp_fault=00, rsp_pc=0, busy=0, FSM=IDLE. Array contents are not reset.
- Ready rule: req_ready = (state==IDLE) & ~ld_en & (~rsp_valid | rsp_ready). Purely combinational; it never depends on req_valid.
- Accept and latency: a request is accepted on a clk edge where req_valid & req_ready. The response registers load on that edge, so rsp_valid rises the next cycle. Latency is 1 cycle.
- Throughput: back-to-back accepts give 1 word per cycle when rsp_ready is held high.
- Response hold: rsp_valid stays high and rsp_instr, rsp_fault and rsp_pc stay stable until the cycle with rsp_ready=1. On that edge, if no new accept occurs, rsp_valid clears to 0.
- Fault decode: misaligned uses pc[1:0]. Range uses the full pc[31:2] compared against DEPTH; there is no truncation or aliasing.
- Any fault returns rsp_instr=NOP_WORD, and the array is not read for that response.
- Load port: a write occurs on the edge when ld_en=1 and state==IDLE. ld_en during CLEAR is ignored.
- Load priority: load beats fetch because req_ready is forced low while ld_en=1. There is therefore no same-cycle read/write hazard.
- Read after load: a read accepted the cycle after a write to the same address returns the new data.
- FSM states:
  - IDLE → CLEAR on clr_start. The clear counter loads 0 and busy=1 from the next cycle.
  - In CLEAR, each cycle writes NOP_WORD at counter then increments it. After writing index DEPTH-1 the FSM returns to IDLE; busy drops the cycle after the final write.
  - A clear takes exactly DEPTH cycles. clr_start in CLEAR is ignored.
- Pending response during clear: a response already in the output register when CLEAR starts is held normally until consumed; the handshake continues.
- Clear counter width: ADDR_W+1 bits, so there is no wrap-around during compare.
- Reset mid-operation: reset aborts CLEAR (contents partially cleared and unspecified) and drops any pending response immediately. No request is accepted until reset deasserts.

Test Plan:
- Basic fetch: load words 0..3 with 0x00730293, 0x40730293, 0x01430293, 0x02832283. Fetch pc=0,4,8,12 back-to-back with rsp_ready=1. Expect 4 responses on consecutive cycles, one cycle after each accept, with fault=00 and correct rsp_pc.
- Backpressure: hold rsp_ready=0 after fetching pc=4. Expect rsp_valid held and rsp_instr stable, and req_ready=0 until rsp_ready=1. Then expect the next request accepted that same cycle.
- Faults:
  - pc=0x6 gives rsp_fault=01 and instr=0x00000013.
  - pc=0x200 with DEPTH=128 gives 10.
  - pc=0x202 gives 11.
  - pc=0x1FC gives 00 with valid data.
- Load/fetch collision: assert ld_en and req_valid in the same cycle. Expect req_ready=0 and no accept. Next cycle fetch the same address and expect the newly loaded word.
- Clear: pulse clr_start. Expect busy high for exactly DEPTH cycles, ld_en ignored during that window, then fetches of pc=0 and pc=0x1FC return 0x00000013.
- Reset: assert reset mid-CLEAR and with rsp_valid=1. Expect busy=0, rsp_valid=0 and req_ready=0 asynchronously. Normal fetch resumes one cycle after deassert.
